ip_dram_arbiter: RTL and testbench
==================================

# ip_dram_arbiter

Two-port arbiter that shares the single DDR3-SDRAM controller bus (27-bit word address, 128-bit data, 16-bit byte mask) between two requesters: port 0 for the Z80-side test controller and port 1 for a second master such as the VDP. It holds off all traffic while the SDRAM is still initialising. It serialises accepted commands onto the controller bus. It tracks outstanding reads in an in-order tag FIFO so each `rdata_en` returns only to the port that issued the read.

## Interface
- `TAG_DEPTH`, 4 — maximum outstanding reads; power of two, 2..16.
- `clk`  in  1  — controller user clock, the same clock that drives the DDR3 controller bus.
- `reset`  in  1  — asynchronous, active-high reset.
- `sdram_init_busy`  in  1  — 1 while the DDR3 controller is initialising; no command is issued while high.
- `p0_address`, `p1_address`  in  27  — request address: [26:24] bank, [23:10] row, [9:0] column.
- `p0_write`, `p1_write`  in  1  — 1 = write, 0 = read.
- `p0_valid`, `p1_valid`  in  1  — request present.
- `p0_ready`, `p1_ready`  out  1  — request accepted this cycle.
- `p0_wdata`, `p1_wdata`  in  128  — write data.
- `p0_wdata_mask`, `p1_wdata_mask`  in  16  — byte mask, passed through unchanged.
- `p0_rdata`, `p1_rdata`  out  128  — read data; all zero when the matching `rdata_en` is 0.
- `p0_rdata_en`, `p1_rdata_en`  out  1  — one-cycle read-data strobe.
- `dram_address`  out  27  — command address to the controller.
- `dram_write`  out  1  — command direction to the controller.
- `dram_valid`  out  1  — command present to the controller.
- `dram_wdata`  out  128  — write data to the controller.
- `dram_wdata_mask`  out  16  — byte mask to the controller.
- `dram_ready`  in  1  — controller accepted the command this cycle.
- `dram_rdata`  in  128  — read data from the controller.
- `dram_rdata_en`  in  1  — read-data strobe from the controller.
- `tag_error`  out  1  — sticky; set when `dram_rdata_en` arrives while the tag FIFO is empty.

## Operation
- Handshake rule: a transfer occurs when `valid & ready` are both high in the same cycle. A requester holds `valid` and its payload stable until `ready`.
- State machine `ST_IDLE` / `ST_ISSUE`:
  - In `ST_IDLE`, with `sdram_init_busy` = 0, choose an eligible port, latch its address/write/wdata/mask into the `dram_*` registers, record it in `grant`, and go to `ST_ISSUE`.
  - A port is eligible if its `valid` = 1 and it is either a write or the tag FIFO is not full.
  - In `ST_ISSUE`, `dram_valid` = 1. When `dram_ready` = 1, `p<grant>_ready` = 1 combinationally, `dram_valid` drops next cycle, and the state returns to `ST_IDLE`.
- `sdram_init_busy` rising while in `ST_ISSUE` does not abort the command already presented.
- Read acceptance pushes `grant` into the tag FIFO.
- `dram_rdata_en` pops the FIFO. The popped id selects which port gets `rdata_en` and `rdata` (registered); the other port sees zeros.
- A push and a pop in the same cycle are legal: occupancy is unchanged.
- A full FIFO blocks read grants even if a pop happens that cycle. Writes are unaffected by FIFO state.
- `dram_rdata_en` while the FIFO is empty: the data is dropped, no port strobes, and `tag_error` is set. Only reset clears `tag_error`.
- Reset mid-operation: state, grant and FIFO are cleared at once. Outstanding reads are lost; later stray strobes set `tag_error`.

## Timing
- Reset values:
  - `dram_valid`, `dram_write`, all `p*_ready`, `p*_rdata_en` and `tag_error` = 0.
  - `dram_address`, `dram_wdata` and `dram_wdata_mask` = 0.
  - All `p*_rdata` = 0.
  - State = `ST_IDLE`; round-robin pointer = port 1, so port 0 wins the first tie.
- Request with `valid` at cycle N (controller idle, `dram_ready` held 1): `dram_valid` at N+1, `p_ready` at N+1, `dram_valid` low at N+2. The next grant can appear at N+3.
- Maximum throughput is one command every 2 cycles.
- Read return: `dram_rdata_en` at cycle M gives `p<id>_rdata_en` and `p<id>_rdata` at M+1.
- `p*_ready` is the only combinational output (`dram_ready & ST_ISSUE & grant`).

## Configuration
- `DRAM_ARB_ROUND_ROBIN_EN` defined: on a tie, grant the port not granted last; the pointer updates on every acceptance.
- Undefined: fixed priority, port 0 always wins ties; port 1 can starve.

## Structure
- Package `ip_dram_arbiter_pkg`:
  - state encoding `ST_IDLE` = 1'b0, `ST_ISSUE` = 1'b1;
  - width constants `DRAM_ADDR_W` = 27, `DRAM_DATA_W` = 128, `DRAM_MASK_W` = 16.
- Sub-module `ip_dram_tag_fifo`: 1-bit wide, `TAG_DEPTH` deep, with push, pop, full and empty flags, and count width log2(`TAG_DEPTH`)+1.

## Test plan
- `sdram_init_busy` = 1, `p0_valid` = 1 read → `dram_valid` stays 0. Drop busy → `dram_valid` asserted 1 cycle later with `p0_address` on `dram_address`.
- Both ports assert a write at the same cycle, with `DRAM_ARB_ROUND_ROBIN_EN` defined → grant order p0, p1, p0, p1. Undefined → p0 every time while `p0_valid` stays high.
- p0 reads 27'h0000100, then p1 reads 27'h1000200; controller returns 128'hA… then 128'hB… → `p0_rdata_en` with the A data, then `p1_rdata_en` with the B data. The non-target `rdata` stays 0.
- Issue `TAG_DEPTH` (4) reads with no return → a 5th read is not granted, while a p1 write is still granted. One `dram_rdata_en` → the read is granted 2 cycles later.
- `dram_rdata_en` with no outstanding read → no port strobes and `tag_error` = 1 until reset.
- Assert `reset` while in `ST_ISSUE` → `dram_valid` = 0 with no clock edge, FIFO empty, state `ST_IDLE` after release.

Source files
------------

// File: rtl/ip_dram_arbiter_pkg.sv
// Shared encodings and bus widths for the two-port DDR3 command arbiter.
package ip_dram_arbiter_pkg;

    // Arbiter state encoding (kept as plain constants for legacy tools)
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam int DRAM_ADDR_W = 27;
    localparam int DRAM_DATA_W = 128;
    localparam int DRAM_MASK_W = 16;

    // One command as presented to the controller bus
    typedef struct packed {
        logic [DRAM_ADDR_W-1:0] address;
        logic                   write;
        logic [DRAM_DATA_W-1:0] wdata;
        logic [DRAM_MASK_W-1:0] mask;
    } dram_cmd_t;

endpackage

// File: rtl/ip_dram_tag_fifo.sv
// In-order FIFO of 1-bit port ids, one entry per read still awaiting data.
// Push while full and pop while empty are ignored; the arbiter never grants
// a read into a full FIFO and flags pops on an empty one itself.
module ip_dram_tag_fifo
    import ip_dram_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic pop_id,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_DEPTH-1:0] mem;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CNT_W'(TAG_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_id  = mem[rd_ptr];

    // Ring buffer pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ip_dram_arbiter.sv
// Two-port arbiter in front of the DDR3 controller command bus.
// Port 0 wins ties unless DRAM_ARB_ROUND_ROBIN_EN is defined, in which case
// ties alternate starting with port 0. Read data is steered back to the
// issuing port using an in-order tag FIFO.
module ip_dram_arbiter
    import ip_dram_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sdram_init_busy,
    input  logic [DRAM_ADDR_W-1:0] p0_address,
    input  logic                   p0_write,
    input  logic                   p0_valid,
    output logic                   p0_ready,
    input  logic [DRAM_DATA_W-1:0] p0_wdata,
    input  logic [DRAM_MASK_W-1:0] p0_wdata_mask,
    output logic [DRAM_DATA_W-1:0] p0_rdata,
    output logic                   p0_rdata_en,
    input  logic [DRAM_ADDR_W-1:0] p1_address,
    input  logic                   p1_write,
    input  logic                   p1_valid,
    output logic                   p1_ready,
    input  logic [DRAM_DATA_W-1:0] p1_wdata,
    input  logic [DRAM_MASK_W-1:0] p1_wdata_mask,
    output logic [DRAM_DATA_W-1:0] p1_rdata,
    output logic                   p1_rdata_en,
    output logic [DRAM_ADDR_W-1:0] dram_address,
    output logic                   dram_write,
    output logic                   dram_valid,
    output logic [DRAM_DATA_W-1:0] dram_wdata,
    output logic [DRAM_MASK_W-1:0] dram_wdata_mask,
    input  logic                   dram_ready,
    input  logic [DRAM_DATA_W-1:0] dram_rdata,
    input  logic                   dram_rdata_en,
    output logic                   tag_error
);

    logic [0:0] state;
    logic       grant;
    logic [1:0] elig;
    logic       sel;
    logic       accept;
    logic       rd_hit;
    logic       tag_full;
    logic       tag_empty;
    logic       tag_id;
    dram_cmd_t  cmd_mux;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    logic       rr_last;
`endif

    // A read needs a free tag slot; writes never wait on the FIFO
    assign elig     = {p1_valid, p0_valid} & ({p1_write, p0_write} | {2{~tag_full}});
    assign accept   = (state == ST_ISSUE) & dram_ready;
    assign p0_ready = accept & ~grant;
    assign p1_ready = accept & grant;
    assign dram_valid = (state == ST_ISSUE);
    assign rd_hit   = dram_rdata_en & ~tag_empty;
    assign cmd_mux  = sel ? {p1_address, p1_write, p1_wdata, p1_wdata_mask}
                          : {p0_address, p0_write, p0_wdata, p0_wdata_mask};

    // Pick the winning port; only a tie consults the priority rule
    always_comb begin
        sel = ~elig[0];
        if (&elig) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
            sel = ~rr_last;
`else
            sel = 1'b0;
`endif
        end
    end

`ifdef DRAM_ARB_ROUND_ROBIN_EN
    // Remember the last accepted port so the next tie goes the other way
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       rr_last <= 1'b1;
        else if (accept) rr_last <= grant;
    end
`endif

    // Latch the winner's command in IDLE, hold it on the bus until the controller takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            grant           <= 1'b0;
            dram_address    <= '0;
            dram_write      <= 1'b0;
            dram_wdata      <= '0;
            dram_wdata_mask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (~sdram_init_busy && (|elig)) begin
                        state           <= ST_ISSUE;
                        grant           <= sel;
                        dram_address    <= cmd_mux.address;
                        dram_write      <= cmd_mux.write;
                        dram_wdata      <= cmd_mux.wdata;
                        dram_wdata_mask <= cmd_mux.mask;
                    end
                end
                default: begin
                    if (dram_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

    // Steer returning read data to the port at the FIFO head; a strobe with no owner is an error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_rdata_en <= 1'b0;
            p1_rdata_en <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            tag_error   <= 1'b0;
        end else begin
            p0_rdata_en <= rd_hit & ~tag_id;
            p1_rdata_en <= rd_hit & tag_id;
            p0_rdata    <= (rd_hit & ~tag_id) ? dram_rdata : '0;
            p1_rdata    <= (rd_hit & tag_id)  ? dram_rdata : '0;
            if (dram_rdata_en & tag_empty) tag_error <= 1'b1;
        end
    end

    ip_dram_tag_fifo #(
        .TAG_DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept & ~dram_write),
        .push_id (grant),
        .pop     (dram_rdata_en),
        .pop_id  (tag_id),
        .full    (tag_full),
        .empty   (tag_empty)
    );

endmodule

// File: tb/tb_ip_dram_arbiter.sv
// Bench for ip_dram_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model (pending command,
// queue of outstanding read owners, sticky error flag).
module tb_ip_dram_arbiter;

    localparam int TAG_DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         sdram_init_busy;
    logic         p0_valid, p0_write, p0_ready, p0_rdata_en;
    logic         p1_valid, p1_write, p1_ready, p1_rdata_en;
    logic [26:0]  p0_address, p1_address, dram_address;
    logic [127:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, dram_wdata, dram_rdata;
    logic [15:0]  p0_wdata_mask, p1_wdata_mask, dram_wdata_mask;
    logic         dram_write, dram_valid, dram_ready, dram_rdata_en, tag_error;

    // requester stimulus, one slot per port
    logic         s_valid [2];
    logic         s_write [2];
    logic [26:0]  s_addr  [2];
    logic [127:0] s_wdata [2];
    logic [15:0]  s_mask  [2];

    assign p0_valid = s_valid[0];  assign p1_valid = s_valid[1];
    assign p0_write = s_write[0];  assign p1_write = s_write[1];
    assign p0_address = s_addr[0]; assign p1_address = s_addr[1];
    assign p0_wdata = s_wdata[0];  assign p1_wdata = s_wdata[1];
    assign p0_wdata_mask = s_mask[0]; assign p1_wdata_mask = s_mask[1];

    ip_dram_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .reset(reset), .sdram_init_busy(sdram_init_busy),
        .p0_address(p0_address), .p0_write(p0_write), .p0_valid(p0_valid), .p0_ready(p0_ready),
        .p0_wdata(p0_wdata), .p0_wdata_mask(p0_wdata_mask), .p0_rdata(p0_rdata), .p0_rdata_en(p0_rdata_en),
        .p1_address(p1_address), .p1_write(p1_write), .p1_valid(p1_valid), .p1_ready(p1_ready),
        .p1_wdata(p1_wdata), .p1_wdata_mask(p1_wdata_mask), .p1_rdata(p1_rdata), .p1_rdata_en(p1_rdata_en),
        .dram_address(dram_address), .dram_write(dram_write), .dram_valid(dram_valid),
        .dram_wdata(dram_wdata), .dram_wdata_mask(dram_wdata_mask), .dram_ready(dram_ready),
        .dram_rdata(dram_rdata), .dram_rdata_en(dram_rdata_en), .tag_error(tag_error)
    );

    // reference model state
    bit           m_busy, m_port, m_wr, m_err;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    bit           m_last;
`endif
    logic [26:0]  m_addr;
    logic [127:0] m_wd;
    logic [15:0]  m_mk;
    bit           m_q [$];
    bit [1:0]     m_ren;
    logic [127:0] m_rd [2];

    bit [1:0]     obs_rdy;
    int           n_chk = 0;
    int           n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_busy = 0; m_port = 0; m_wr = 0; m_err = 0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        m_last = 1;
`endif
        m_addr = '0; m_wd = '0; m_mk = '0;
        m_q.delete();
        m_ren = 2'b00; m_rd[0] = '0; m_rd[1] = '0;
    endfunction

    task automatic req(input int i, input bit v, input bit w, input logic [26:0] a);
        s_valid[i] = v; s_write[i] = w; s_addr[i] = a;
        s_wdata[i] = {$urandom, $urandom, $urandom, $urandom};
        s_mask[i]  = 16'($urandom);
    endtask

    task automatic idle_inputs();
        sdram_init_busy = 0; dram_ready = 0; dram_rdata_en = 0; dram_rdata = '0;
        for (int i = 0; i < 2; i++) req(i, 0, 0, '0);
    endtask

    // One clock: check outputs mid-cycle, advance the model, return just after the edge
    task automatic cyc();
        bit full, id, s;
        bit [1:0] el;
        bit [1:0] rdy;
        @(negedge clk);
        rdy = 2'b00;
        if (m_busy && dram_ready) rdy[m_port] = 1'b1;
        obs_rdy = {p1_ready, p0_ready};
        chk("dram_valid", dram_valid, m_busy);
        chk("dram_address", dram_address, m_addr);
        chk("dram_write", dram_write, m_wr);
        chk("dram_wdata", dram_wdata, m_wd);
        chk("dram_mask", dram_wdata_mask, m_mk);
        chk("p0_ready", p0_ready, rdy[0]);
        chk("p1_ready", p1_ready, rdy[1]);
        chk("p0_rdata_en", p0_rdata_en, m_ren[0]);
        chk("p1_rdata_en", p1_rdata_en, m_ren[1]);
        chk("p0_rdata", p0_rdata, m_rd[0]);
        chk("p1_rdata", p1_rdata, m_rd[1]);
        chk("tag_error", tag_error, m_err);
        if (reset) model_reset();
        else begin
            full = (m_q.size() >= TAG_DEPTH);
            m_ren = 2'b00; m_rd[0] = '0; m_rd[1] = '0;
            if (dram_rdata_en) begin
                if (m_q.size() == 0) m_err = 1;
                else begin
                    id = m_q.pop_front();
                    m_ren[id] = 1'b1;
                    m_rd[id]  = dram_rdata;
                end
            end
            if (m_busy) begin
                if (dram_ready) begin
                    if (!m_wr) m_q.push_back(m_port);
`ifdef DRAM_ARB_ROUND_ROBIN_EN
                    m_last = m_port;
`endif
                    m_busy = 0;
                end
            end else if (!sdram_init_busy) begin
                for (int i = 0; i < 2; i++) el[i] = s_valid[i] && (s_write[i] || !full);
                if (el != 2'b00) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
                    s = (el == 2'b11) ? !m_last : el[1];
`else
                    s = (el == 2'b11) ? 1'b0 : el[1];
`endif
                    m_busy = 1; m_port = s; m_wr = s_write[s];
                    m_addr = s_addr[s]; m_wd = s_wdata[s]; m_mk = s_mask[s];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Async reset: outputs must fall before any clock edge
    task automatic do_reset();
        reset = 1;
        model_reset();
        #1;
        chk("rst_dram_valid", dram_valid, 1'b0);
        idle_inputs();
        cyc();
        reset = 0;
    endtask

    initial begin
        int n, n0, n1;
        bit got_order [4];
        bit exp_order [4];

        idle_inputs();
        do_reset();

        // init busy holds off commands
        sdram_init_busy = 1; dram_ready = 1;
        req(0, 1, 0, 27'h0000100);
        repeat (3) cyc();
        chk("busy_hold", dram_valid, 1'b0);
        sdram_init_busy = 0;
        cyc();
        chk("busy_release_valid", dram_valid, 1'b1);
        chk("busy_release_addr", dram_address, 27'h0000100);
        cyc();
        s_valid[0] = 0;
        cyc();

        // grant order with both ports writing continuously
        do_reset();
        dram_ready = 1;
        req(0, 1, 1, 27'($urandom));
        req(1, 1, 1, 27'($urandom));
        n = 0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            cyc();
            if (obs_rdy != 2'b00) begin
                got_order[n] = obs_rdy[1];
                n++;
                if (obs_rdy[0]) req(0, 1, 1, 27'($urandom));
                if (obs_rdy[1]) req(1, 1, 1, 27'($urandom));
            end
        end
        chk("grant_count", n, 4);
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 4; k++) chk($sformatf("grant_order%0d", k), got_order[k], exp_order[k]);

        // read data routed back to the issuing port
        do_reset();
        dram_ready = 1;
        req(0, 1, 0, 27'h0000100);
        req(1, 1, 0, 27'h1000200);
        n = 0;
        for (int c = 0; c < 8 && n < 2; c++) begin
            cyc();
            if (obs_rdy[0]) begin s_valid[0] = 0; n++; end
            if (obs_rdy[1]) begin s_valid[1] = 0; n++; end
        end
        chk("rd_issue_count", n, 2);
        dram_rdata_en = 1; dram_rdata = {32{4'hA}};
        cyc();
        dram_rdata_en = 1; dram_rdata = {32{4'hB}};
        chk("rdA_p0_en", p0_rdata_en, 1'b1);
        chk("rdA_p0_data", p0_rdata, {32{4'hA}});
        chk("rdA_p1_en", p1_rdata_en, 1'b0);
        chk("rdA_p1_data", p1_rdata, 128'h0);
        cyc();
        dram_rdata_en = 0; dram_rdata = '0;
        chk("rdB_p1_en", p1_rdata_en, 1'b1);
        chk("rdB_p1_data", p1_rdata, {32{4'hB}});
        chk("rdB_p0_en", p0_rdata_en, 1'b0);
        chk("rdB_p0_data", p0_rdata, 128'h0);
        cyc();

        // full tag FIFO blocks reads but not writes
        do_reset();
        dram_ready = 1;
        n = 0;
        req(0, 1, 0, 27'h0000040);
        for (int c = 0; c < 20 && n < 4; c++) begin
            cyc();
            if (obs_rdy[0]) begin n++; req(0, 1, 0, 27'h0000040 + 27'(n)); end
        end
        chk("full_reads", n, 4);
        req(1, 1, 1, 27'h0000777);
        n0 = 0; n1 = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (obs_rdy[0]) n0++;
            if (obs_rdy[1]) begin n1++; s_valid[1] = 0; end
        end
        chk("full_blocks_read", n0, 0);
        chk("full_write_ok", n1, 1);
        dram_rdata_en = 1;
        cyc();
        dram_rdata_en = 0;
        chk("pop_cycle_no_grant", dram_valid, 1'b0);
        cyc();
        chk("read_after_pop", dram_valid, 1'b1);
        chk("read_after_pop_addr", dram_address, 27'h0000044);
        cyc();
        s_valid[0] = 0;
        cyc();

        // strobe with nothing outstanding
        do_reset();
        dram_rdata_en = 1; dram_rdata = {$urandom, $urandom, $urandom, $urandom};
        cyc();
        dram_rdata_en = 0;
        chk("stray_err", tag_error, 1'b1);
        chk("stray_p0_en", p0_rdata_en, 1'b0);
        chk("stray_p1_en", p1_rdata_en, 1'b0);
        repeat (3) cyc();
        chk("stray_sticky", tag_error, 1'b1);
        do_reset();
        chk("err_cleared", tag_error, 1'b0);

        // reset while a command sits on the bus, with a read outstanding
        dram_ready = 1;
        req(0, 1, 0, 27'h0000123);
        n = 0;
        for (int c = 0; c < 6 && n < 1; c++) begin
            cyc();
            if (obs_rdy[0]) begin n++; req(0, 1, 1, 27'h0000456); dram_ready = 0; end
        end
        chk("pre_reset_read", n, 1);
        cyc();
        cyc();
        chk("issue_before_reset", dram_valid, 1'b1);
        do_reset();
        dram_rdata_en = 1;
        cyc();
        dram_rdata_en = 0;
        chk("lost_read_err", tag_error, 1'b1);
        chk("lost_read_p0_en", p0_rdata_en, 1'b0);

        // random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) do_reset();
            cyc();
            for (int i = 0; i < 2; i++)
                if (obs_rdy[i] || !s_valid[i])
                    req(i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 27'($urandom));
            sdram_init_busy = ($urandom_range(0, 15) == 0);
            dram_ready      = 1'($urandom_range(0, 1));
            dram_rdata_en   = (m_q.size() != 0) ? ($urandom_range(0, 2) == 0)
                                                : ($urandom_range(0, 99) == 0);
            dram_rdata      = {$urandom, $urandom, $urandom, $urandom};
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
